// File: rtl/i2s_transmitter.sv
// I2S master serialiser: shadows one mono sample per frame and sends it MSB-first in both slots.
// Latency: sample latched at frame start goes out the same frame; backpressure: none, sample_en paces the source.
module i2s_transmitter #(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32,
  parameter int SAMPLE_W  = 16
) (
  input  logic                master_clk,
  input  logic                rst_n,
  input  logic                tx_enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                sample_en,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [SAMPLE_W-1:0] r_shadow;
  logic                r_sample_en;
  logic                r_bclk;
  logic                r_lrclk;
  logic                r_sdata;

  logic                w_fall;
  logic                w_frame_start;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic                w_right;
  logic [BIT_W-1:0]    w_pos;
  logic                w_bclk_nxt;
  logic                w_sdata_nxt;

  assign w_fall        = (r_div_cnt == DIV_LAST);
  assign w_div_nxt     = w_fall ? '0 : r_div_cnt + 1'b1;
  assign w_bclk_nxt    = (w_div_nxt >= DIV_HALF);
  assign w_bit_nxt     = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
  assign w_frame_start = w_fall && (r_bit_cnt == BIT_LAST);
  assign w_right       = (w_bit_nxt >= SLOT_LEN);
  assign w_pos         = w_right ? (w_bit_nxt - SLOT_LEN) : w_bit_nxt;

  // Slot position 0 is the one-BCLK I2S delay; positions past the word pad with zeros.
  always_comb begin
    w_sdata_nxt = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (w_pos == BIT_W'(SAMPLE_W - i)) begin
        w_sdata_nxt = r_shadow[i];
      end
    end
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= BIT_LAST;
      r_shadow    <= '0;
      r_sample_en <= 1'b0;
      r_bclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
    end else if (!tx_enable) begin
      // Idle restarts exactly like reset, but the shadow word is kept.
      r_div_cnt   <= '0;
      r_bit_cnt   <= BIT_LAST;
      r_sample_en <= 1'b0;
      r_bclk      <= 1'b0;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_nxt;
      r_bclk      <= w_bclk_nxt;
      r_sample_en <= w_frame_start;
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_right;
        r_sdata   <= w_sdata_nxt;
        if (w_frame_start) begin
          r_shadow <= sample_in;
        end
      end
    end
  end

  assign sample_en = r_sample_en;
  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_sdata = r_sdata;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: frame-level model checked every cycle plus hand-computed frame patterns.
module tb_i2s_transmitter;

  localparam int D  = 4;
  localparam int SB = 32;
  localparam int SW = 16;
  localparam int FB = 2 * SB;

  logic          master_clk = 1'b0;
  logic          rst_n      = 1'b0;
  logic          tx_enable  = 1'b0;
  logic [SW-1:0] sample_in  = '0;
  logic          sample_en;
  logic          i2s_bclk;
  logic          i2s_lrclk;
  logic          i2s_sdata;

  int n_vec = 0;
  int n_err = 0;

  int          m_n      = 0;
  logic [15:0] m_shadow = '0;
  int          e_idx    = 0;
  int          strobes[$];
  logic [7:0]  bclk_hist = '0;
  int          bclk_hist_n = 0;

  logic        cap_on  = 1'b0;
  logic [63:0] cap_bits = '0;
  logic [63:0] cap_lr   = '0;
  int          cap_cnt  = 0;

  i2s_transmitter #(.BCLK_DIV(D), .SLOT_BITS(SB), .SAMPLE_W(SW)) dut (
    .master_clk (master_clk),
    .rst_n      (rst_n),
    .tx_enable  (tx_enable),
    .sample_in  (sample_in),
    .sample_en  (sample_en),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrclk  (i2s_lrclk),
    .i2s_sdata  (i2s_sdata)
  );

  always #5 master_clk = ~master_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_n counts enabled clock edges since the link (re)started.
  always @(posedge master_clk) begin
    int k;
    int b;
    int p;
    int cur;
    logic [3:0] exp;
    cur = -1;
    if (!rst_n) begin
      m_n = 0;
      m_shadow = '0;
      e_idx = 0;
    end else begin
      cur = e_idx;
      e_idx++;
      if (!tx_enable) begin
        m_n = 0;
      end else begin
        m_n++;
        if ((m_n % D == 0) && ((m_n / D - 1) % FB == 0)) m_shadow = sample_in;
      end
    end
    #1;
    exp = 4'b0000;
    if (rst_n) begin
      exp[2] = ((m_n % D) >= D / 2);
      k = m_n / D;
      if (k >= 1) begin
        b = (k - 1) % FB;
        p = b % SB;
        exp[1] = (b >= SB);
        if (p >= 1 && p <= SW) exp[0] = m_shadow[SW - p];
        exp[3] = (m_n % D == 0) && (b == 0);
      end
    end
    check("cycle", {60'd0, sample_en, i2s_bclk, i2s_lrclk, i2s_sdata}, {60'd0, exp});
    if (rst_n && sample_en) strobes.push_back(cur);
    if (rst_n && cur >= 0 && cur < 8) begin
      bclk_hist = {bclk_hist[6:0], i2s_bclk};
      bclk_hist_n++;
    end
  end

  always @(posedge i2s_bclk) begin
    if (cap_on) begin
      cap_bits = {cap_bits[62:0], i2s_sdata};
      cap_lr   = {cap_lr[62:0], i2s_lrclk};
      cap_cnt++;
    end
  end

  task automatic wait_strobe(output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 400) begin
      @(posedge master_clk);
      #1;
      cycles++;
      if (sample_en) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL strobe_timeout: got none expected sample_en within 400 cycles");
    end
  endtask

  task automatic capture_start();
    cap_cnt = 0;
    cap_bits = '0;
    cap_lr = '0;
    cap_on = 1'b1;
  endtask

  task automatic capture_end(input string nm, input logic [63:0] exp_bits);
    int w;
    w = 0;
    while (cap_cnt < 64 && w < 400) begin
      @(posedge master_clk);
      w++;
    end
    cap_on = 1'b0;
    check({nm, "_rises"}, 64'(cap_cnt), 64'd64);
    check({nm, "_sdata"}, cap_bits, exp_bits);
    check({nm, "_lrclk"}, cap_lr, {32'h0000_0000, 32'hFFFF_FFFF});
  endtask

  initial begin
    int c;
    int bad;
    int ns0;

    // Reset held with the link enabled: everything quiet.
    tx_enable = 1'b1;
    sample_in = 16'hA5F0;
    repeat (3) @(negedge master_clk);
    check("reset_outs", {60'd0, sample_en, i2s_bclk, i2s_lrclk, i2s_sdata}, 64'd0);
    rst_n = 1'b1;

    wait_strobe(c);
    check("first_strobe_dly", 64'(c), 64'd4);
    capture_start();
    capture_end("a5f0", {2{32'h52F8_0000}});
    check("bclk_wave", {56'd0, bclk_hist}, {56'd0, 8'b0110_0110});
    check("bclk_hist_n", 64'(bclk_hist_n), 64'd8);

    // Mid-frame sample change must not disturb the word in flight.
    @(negedge master_clk);
    sample_in = 16'h8001;
    wait_strobe(c);
    capture_start();
    repeat (42) @(negedge master_clk);
    sample_in = 16'h7FFF;
    capture_end("8001", {2{32'h4000_8000}});
    wait_strobe(c);
    capture_start();
    capture_end("7fff", {2{32'h3FFF_8000}});

    check("strobe0", 64'(strobes[0]), 64'd3);
    check("strobe1", 64'(strobes[1]), 64'd259);
    check("strobe2", 64'(strobes[2]), 64'd515);
    bad = 0;
    foreach (strobes[i]) if (strobes[i] % 256 != 3) bad++;
    check("stray_strobes", 64'(bad), 64'd0);

    // Reset in the right slot, then the start-up sequence must repeat exactly.
    wait_strobe(c);
    repeat (162) @(negedge master_clk);
    check("pre_reset_lrclk", {63'd0, i2s_lrclk}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {60'd0, sample_en, i2s_bclk, i2s_lrclk, i2s_sdata}, 64'd0);
    repeat (3) @(negedge master_clk);
    strobes.delete();
    rst_n = 1'b1;
    repeat (600) @(negedge master_clk);
    check("rst_strobe_n", 64'(strobes.size()), 64'd3);
    if (strobes.size() == 3) begin
      check("rst_strobe0", 64'(strobes[0]), 64'd3);
      check("rst_strobe1", 64'(strobes[1]), 64'd259);
      check("rst_strobe2", 64'(strobes[2]), 64'd515);
    end

    // Enable gating.
    sample_in = 16'h1234;
    wait_strobe(c);
    repeat (50) @(negedge master_clk);
    tx_enable = 1'b0;
    sample_in = 16'h5678;
    ns0 = strobes.size();
    repeat (100) @(negedge master_clk);
    check("disabled_strobes", 64'(strobes.size()), 64'(ns0));
    check("disabled_outs", {60'd0, sample_en, i2s_bclk, i2s_lrclk, i2s_sdata}, 64'd0);
    tx_enable = 1'b1;
    wait_strobe(c);
    check("reenable_strobe_dly", 64'(c), 64'd4);
    capture_start();
    capture_end("5678", {2{32'h2B3C_0000}});

    repeat (4) @(negedge master_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
